ram_port_ctrl: RTL and testbench
================================

# ram_port_ctrl

Front-end controller for the 4 KB split instruction/data SDPRAM. It arbitrates a core's instruction-fetch port and data load/store port onto the RAM's single read port and single write port. It enforces the address map, and implements byte-strobed stores as read-modify-write. Each transaction returns exactly one response pulse, one cycle after its grant.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width of both requesters.
- `MEM_BYTES`, 4096: total RAM size. Bytes 0x000–0x7FF are imem; bytes 0x800–0xFFF are dmem.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `if_req_i`  in  1  fetch request.
- `if_addr_i`  in  32  fetch byte address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch data valid.
- `if_rdata_o`  out  32  fetch data; 0 when `if_rvalid_o` is low.
- `d_req_i`  in  1  data request.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_be_i`  in  4  store byte enables; bit n covers bits [8n+7:8n].
- `d_addr_i`  in  32  data byte address.
- `d_wdata_i`  in  32  store data.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  response to a load or store.
- `d_rdata_o`  out  32  load data; 0 otherwise.
- `d_err_o`  out  1  qualifies `d_rvalid_o`; access was refused.
- `ram_cs_o`, `ram_re_o`, `ram_we_o`  out  1 each  RAM controls.
- `ram_raddr_o`, `ram_waddr_o`  out  32 each  word-aligned byte addresses to the RAM.
- `ram_wdata_o`  out  32  RAM write data.
- `ram_rdata_i`  in  32  RAM read data, registered inside the RAM; valid the cycle after `cs&re`.

## Operation
- FSM states and transitions:
  - IDLE → RD_WAIT on a granted load, a granted fetch, or a granted partial store.
  - IDLE → ACK on a granted full-word store or a `be=0000` store.
  - IDLE → ERR on a granted illegal access.
  - RD_WAIT, ACK and ERR always return to IDLE after one cycle.
  - RD_WAIT carries `owner` (IF/D) and a `rmw` flag.
- Grants are issued only in IDLE, combinationally from the requests. At most one grant is issued per cycle.
- Arbitration:
  - A single requester is granted immediately.
  - When both request, the requester not granted last wins.
  - `last_gnt` resets to IF, so the first contention goes to D.
- Address handling: bits [1:0] are forced to 0 on the RAM address.
- Illegal accesses:
  - Any address ≥ `MEM_BYTES`.
  - A store to imem (address < 0x800).
  - An illegal access makes no RAM access and produces an `err=1` response.
  - A fetch to an illegal address also takes the ERR state. `if_rvalid_o` pulses with `if_rdata_o=0`, and `d_err_o` is not asserted.
- Loads and fetches: in the grant cycle, drive `ram_cs_o=1`, `ram_re_o=1` and `ram_raddr_o`. In RD_WAIT, pass `ram_rdata_i` to the owner's rdata and pulse the owner's rvalid.
- Full store (`be=1111`): in the grant cycle, drive `ram_cs_o=1`, `ram_we_o=1`, `ram_waddr_o` and `ram_wdata_o=d_wdata_i`. In ACK, pulse `d_rvalid_o`.
- Partial store:
  - Grant cycle: read the word and latch `d_wdata_i`, `d_be_i` and the address.
  - RD_WAIT: drive `ram_we_o=1`, with each byte taken from the latched wdata when its latched be bit is set, otherwise from `ram_rdata_i`.
  - RD_WAIT also pulses `d_rvalid_o`.
- `be=0000` store: no RAM write; normal ack.
- No cycle drives both `ram_re_o` and `ram_we_o` for a transaction, except that an RMW read and its write occur in different cycles.

## Timing
- Reset values: state IDLE, `last_gnt` IF. All outputs are 0, including `ram_cs_o`, `ram_re_o` and `ram_we_o`.
- Reset mid-transaction discards the transaction; no response is produced.
- Latency: the response arrives exactly 1 cycle after the grant for every transaction type.
- Throughput: one transaction per 2 cycles. Requesters hold request, address and data until granted.
- Requests seen in a non-IDLE state are ignored (no grant) and re-evaluated in IDLE.
- A response pulse is exactly 1 cycle wide, and only one rvalid is high per cycle.

## Structure
- Package `ram_ctrl_pkg`:
  - `state_e` enum {IDLE, RD_WAIT, ACK, ERR}.
  - `owner_e` enum {OWN_IF, OWN_D}.
  - Constants `IMEM_BASE=32'h000`, `DMEM_BASE=32'h800`, `MEM_END=32'h1000`.
- Sub-module `ram_byte_merge`: combinational merge of old word, new word and be into the merged word. Instantiated once.

## Test plan
- Fetch at 0x004 (imem[1]=0xDEADBEEF) → `if_gnt_o` in cycle 0; `if_rvalid_o=1` with `if_rdata_o=0xDEADBEEF` in cycle 1.
- Full store 0x12345678 to 0x800, then load 0x800 → `d_rvalid_o` 1 cycle after each grant; load returns 0x12345678.
- Word at 0x804 = 0xAABBCCDD; store 0x00001100 with `be=0010` → RAM written 0xAABB11DD in cycle 1; a subsequent load returns 0xAABB11DD.
- Store to 0x010 and load from 0x1000 → no `ram_cs_o`; `d_rvalid_o=1` and `d_err_o=1` one cycle after each grant.
- `if_req_i` and `d_req_i` held high together for 8 cycles → grants alternate D, IF, D, IF, one per 2 cycles; never both in one cycle.
- `rst_ni` asserted low during RD_WAIT → all outputs 0 immediately; no rvalid after release; the next request is granted in its first cycle.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared types and address-map constants for the SDPRAM front-end controller.
//   state_e : controller FSM states
//   owner_e : which requester a pending transaction belongs to
//   IMEM_BASE / DMEM_BASE / MEM_END : byte address map of the 4 KB RAM
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2,
        ERR     = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE = 32'h0000_0800;
    localparam logic [31:0] MEM_END   = 32'h0000_1000;

endpackage

// File: rtl/ram_byte_merge.sv
// ram_byte_merge
// Combinational byte merge used by read-modify-write stores.
//   old_i    : word currently held in the RAM
//   new_i    : store data
//   be_i     : byte enables, bit n selects new_i[8n+7:8n]
//   merged_o : word to write back
module ram_byte_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign merged_o[8*b +: 8] = be_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl
// Arbitrates an instruction-fetch port and a data load/store port onto a
// simple dual-port RAM (one read port, one write port, registered read data).
// Enforces the imem/dmem address map and performs byte-strobed stores as
// read-modify-write. Every granted transaction gets exactly one response
// pulse in the cycle after its grant.
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   if_req/addr_i, if_gnt/rvalid/rdata_o          : fetch port
//   d_req/we/be/addr/wdata_i, d_gnt/rvalid/rdata/err_o : data port
//   ram_cs/re/we_o, ram_raddr/waddr/wdata_o, ram_rdata_i : RAM side
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,
    output logic              ram_cs_o,
    output logic              ram_re_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    localparam logic [ADDR_W-1:0] DMEM_A = ADDR_W'(DMEM_BASE);
    localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(MEM_BYTES);

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              rmw_q, rmw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       merged;

    logic if_bad, d_bad, arb_if, arb_d;

    assign if_bad = (if_addr_i >= END_A);
    assign d_bad  = (d_addr_i >= END_A) || (d_we_i && (d_addr_i < DMEM_A));

    // On contention the requester that did not win last time is served.
    assign arb_if = if_req_i && (!d_req_i || (last_q == OWN_D));
    assign arb_d  = d_req_i && (!if_req_i || (last_q == OWN_IF));

    ram_byte_merge u_merge (
        .old_i    (ram_rdata_i),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    // NOTE: every signal written below gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rmw_d       = rmw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        d_err_o     = 1'b0;
        ram_cs_o    = 1'b0;
        ram_re_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_raddr_o = '0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                // Grants are combinational from the requests; qualifying with
                // rst_ni keeps every output at 0 while reset is held.
                if (rst_ni && arb_if) begin
                    if_gnt_o = 1'b1;
                    last_d   = OWN_IF;
                    owner_d  = OWN_IF;
                    rmw_d    = 1'b0;
                    if (if_bad) begin
                        state_d = ERR;
                    end else begin
                        ram_cs_o    = 1'b1;
                        ram_re_o    = 1'b1;
                        ram_raddr_o = align(if_addr_i);
                        state_d     = RD_WAIT;
                    end
                end else if (rst_ni && arb_d) begin
                    d_gnt_o = 1'b1;
                    last_d  = OWN_D;
                    owner_d = OWN_D;
                    rmw_d   = 1'b0;
                    if (d_bad) begin
                        state_d = ERR;
                    end else if (!d_we_i) begin
                        ram_cs_o    = 1'b1;
                        ram_re_o    = 1'b1;
                        ram_raddr_o = align(d_addr_i);
                        state_d     = RD_WAIT;
                    end else if (d_be_i == 4'b1111) begin
                        ram_cs_o    = 1'b1;
                        ram_we_o    = 1'b1;
                        ram_waddr_o = align(d_addr_i);
                        ram_wdata_o = d_wdata_i;
                        state_d     = ACK;
                    end else if (d_be_i == 4'b0000) begin
                        state_d = ACK;
                    end else begin
                        // Partial store: fetch the old word now, merge next cycle.
                        ram_cs_o    = 1'b1;
                        ram_re_o    = 1'b1;
                        ram_raddr_o = align(d_addr_i);
                        rmw_d       = 1'b1;
                        addr_d      = align(d_addr_i);
                        wdata_d     = d_wdata_i;
                        be_d        = d_be_i;
                        state_d     = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                if (owner_q == OWN_IF) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = ram_rdata_i;
                end else begin
                    d_rvalid_o = 1'b1;
                    if (rmw_q) begin
                        ram_cs_o    = 1'b1;
                        ram_we_o    = 1'b1;
                        ram_waddr_o = addr_q;
                        ram_wdata_o = merged;
                    end else begin
                        d_rdata_o = ram_rdata_i;
                    end
                end
            end
            ACK: begin
                state_d    = IDLE;
                d_rvalid_o = 1'b1;
            end
            ERR: begin
                state_d = IDLE;
                if (owner_q == OWN_IF) begin
                    if_rvalid_o = 1'b1;
                end else begin
                    d_rvalid_o = 1'b1;
                    d_err_o    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            rmw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rmw_q   <= rmw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl
// Self-checking bench for ram_port_ctrl: a RAM model on the RAM side, directed
// transactions with literal expectations, and a randomized phase. A reference
// model predicts every output on every falling edge.
module tb_ram_port_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic        ram_cs_o, ram_re_o, ram_we_o;
    logic [31:0] ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    ram_port_ctrl #(.ADDR_W(32), .MEM_BYTES(4096)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .d_err_o     (d_err_o),
        .ram_cs_o    (ram_cs_o),
        .ram_re_o    (ram_re_o),
        .ram_we_o    (ram_we_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 1)      return 32'hDEAD_BEEF;
        if (i == 'h201)  return 32'hAABB_CCDD;
        return (i * 32'h9E37_79B9) + 32'h1234;
    endfunction

    // RAM model: registered read, synchronous write, 1024 words.
    logic [31:0] ram [0:1023];
    bit          ram_seeded = 0;
    always @(posedge clk_i) begin
        if (!ram_seeded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_seeded <= 1;
        end else begin
            if (ram_cs_o && ram_re_o) ram_rdata_i <= ram[ram_raddr_o[11:2]];
            if (ram_cs_o && ram_we_o) ram[ram_waddr_o[11:2]] <= ram_wdata_o;
        end
    end

    // Reference model: expected memory contents plus the response owed in the
    // current cycle, computed in full at grant time.
    typedef struct packed {
        bit          valid;
        bit          to_if;
        bit          err;
        logic [31:0] rdata;
        bit          wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } resp_t;

    logic [31:0] mdl [0:1023];
    bit          mdl_seeded = 0;
    resp_t       rsp = '0;
    bit          last_d = 0;

    always @(negedge clk_i) begin
        resp_t       nxt;
        logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_re, e_we;
        logic [31:0] e_if_rd, e_d_rd, e_raddr, e_waddr, e_wdata, merged;
        int          w;
        if (!mdl_seeded) begin
            for (int i = 0; i < 1024; i++) mdl[i] = init_word(i);
            mdl_seeded = 1;
        end
        nxt = '0;
        {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_re, e_we} = '0;
        {e_if_rd, e_d_rd, e_raddr, e_waddr, e_wdata} = '0;
        if (!rst_ni) begin
            last_d = 0;
        end else if (rsp.valid) begin
            if (rsp.to_if) begin
                e_if_rv = 1; e_if_rd = rsp.rdata;
            end else begin
                e_d_rv = 1; e_d_rd = rsp.rdata; e_err = rsp.err;
            end
            if (rsp.wr) begin
                e_we = 1; e_waddr = rsp.waddr; e_wdata = rsp.wdata;
            end
        end else begin
            if (if_req_i && d_req_i) begin
                e_d_gnt = !last_d; e_if_gnt = last_d;
            end else begin
                e_if_gnt = if_req_i; e_d_gnt = d_req_i;
            end
            if (e_if_gnt) begin
                last_d = 0; nxt.valid = 1; nxt.to_if = 1;
                if (if_addr_i < 32'h1000) begin
                    e_re = 1; e_raddr = if_addr_i & 32'hFFFF_FFFC;
                    nxt.rdata = mdl[if_addr_i[11:2]];
                end
            end else if (e_d_gnt) begin
                last_d = 1; nxt.valid = 1;
                w = int'(d_addr_i[11:2]);
                if (d_addr_i >= 32'h1000 || (d_we_i && d_addr_i < 32'h800)) begin
                    nxt.err = 1;
                end else if (!d_we_i) begin
                    e_re = 1; e_raddr = d_addr_i & 32'hFFFF_FFFC;
                    nxt.rdata = mdl[w];
                end else begin
                    merged = mdl[w];
                    for (int b = 0; b < 4; b++)
                        if (d_be_i[b]) merged[8*b +: 8] = d_wdata_i[8*b +: 8];
                    mdl[w] = merged;
                    if (d_be_i == 4'hF) begin
                        e_we = 1; e_waddr = d_addr_i & 32'hFFFF_FFFC; e_wdata = merged;
                    end else if (d_be_i != 4'h0) begin
                        e_re = 1; e_raddr = d_addr_i & 32'hFFFF_FFFC;
                        nxt.wr = 1; nxt.waddr = e_raddr; nxt.wdata = merged;
                    end
                end
            end
        end
        check("if_gnt", if_gnt_o, e_if_gnt);
        check("d_gnt", d_gnt_o, e_d_gnt);
        check("if_rvalid", if_rvalid_o, e_if_rv);
        check("if_rdata", if_rdata_o, e_if_rd);
        check("d_rvalid", d_rvalid_o, e_d_rv);
        check("d_rdata", d_rdata_o, e_d_rd);
        check("d_err", d_err_o, e_err);
        check("ram_cs", ram_cs_o, e_re | e_we);
        check("ram_re", ram_re_o, e_re);
        check("ram_we", ram_we_o, e_we);
        if (e_re || !rst_ni) check("ram_raddr", ram_raddr_o, e_raddr);
        if (e_we || !rst_ni) begin
            check("ram_waddr", ram_waddr_o, e_waddr);
            check("ram_wdata", ram_wdata_o, e_wdata);
        end
        rsp = nxt;
    end

    // Results of the most recent directed transaction.
    int          r_waits;
    logic        r_cs_gnt, r_rv, r_err, r_we;
    logic [31:0] r_rdata, r_wdata;

    // Called just after a rising edge; returns just after a rising edge.
    task automatic txn(input bit is_if, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bit granted = 0;
        if (is_if) begin
            if_req_i = 1; if_addr_i = addr;
        end else begin
            d_req_i = 1; d_we_i = we; d_be_i = be; d_addr_i = addr; d_wdata_i = wdata;
        end
        r_waits = 0;
        while (!granted && r_waits < 20) begin
            @(negedge clk_i);
            granted  = is_if ? if_gnt_o : d_gnt_o;
            r_cs_gnt = ram_cs_o;
            if (!granted) r_waits++;
        end
        check("txn_granted", 32'(granted), 1);
        @(posedge clk_i); #1;
        if_req_i = 0; d_req_i = 0;
        @(negedge clk_i);
        r_rv    = is_if ? if_rvalid_o : d_rvalid_o;
        r_rdata = is_if ? if_rdata_o : d_rdata_o;
        r_err   = d_err_o;
        r_we    = ram_we_o;
        r_wdata = ram_wdata_o;
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
    endtask

    logic [31:0] rnd_addr;
    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h17FF));
    endfunction

    initial begin
        logic [1:0] gseq [8];
        logic [1:0] gexp [8];
        bit         g_if, g_d;
        if_req_i = 0; if_addr_i = 0;
        d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
        rst_ni = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ctrl", 32'({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o,
                               ram_cs_o, ram_re_o, ram_we_o}), 0);
        check("rst_data", if_rdata_o | d_rdata_o | ram_raddr_o | ram_waddr_o | ram_wdata_o, 0);
        rst_ni = 1;

        // Fetch from imem[1].
        txn(1, 0, 4'h0, 32'h004, 0);
        check("fetch_wait", r_waits, 0);
        check("fetch_rvalid", r_rv, 1);
        check("fetch_rdata", r_rdata, 32'hDEAD_BEEF);
        // Full store then load back.
        txn(0, 1, 4'hF, 32'h800, 32'h1234_5678);
        check("fstore_cs", r_cs_gnt, 1);
        check("fstore_rvalid", r_rv, 1);
        check("fstore_err", r_err, 0);
        txn(0, 0, 4'h0, 32'h800, 0);
        check("load800_rdata", r_rdata, 32'h1234_5678);
        // Byte-strobed store into 0x804.
        txn(0, 1, 4'b0010, 32'h804, 32'h0000_1100);
        check("rmw_rvalid", r_rv, 1);
        check("rmw_we", r_we, 1);
        check("rmw_wdata", r_wdata, 32'hAABB_11DD);
        txn(0, 0, 4'h0, 32'h806, 0);
        check("load804_rdata", r_rdata, 32'hAABB_11DD);
        // Illegal accesses.
        txn(0, 1, 4'hF, 32'h010, 32'hFFFF_FFFF);
        check("st_imem_cs", r_cs_gnt, 0);
        check("st_imem_err", {r_rv, r_err}, 2'b11);
        txn(0, 0, 4'h0, 32'h1000, 0);
        check("ld_oob_cs", r_cs_gnt, 0);
        check("ld_oob_err", {r_rv, r_err}, 2'b11);
        txn(1, 0, 4'h0, 32'h1000, 0);
        check("if_oob_resp", {r_rv, r_err}, 2'b10);
        check("if_oob_rdata", r_rdata, 0);
        // Empty-strobe store: no write, plain ack.
        txn(0, 1, 4'h0, 32'h808, 32'h5555_5555);
        check("be0_resp", {r_rv, r_err, r_cs_gnt}, 3'b100);

        // Contention from reset: D, IF, D, IF on alternate cycles.
        @(posedge clk_i); #1;
        do_reset();
        if_req_i = 1; if_addr_i = 32'h008;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h800;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            gseq[c] = {d_gnt_o, if_gnt_o};
        end
        @(posedge clk_i); #1;
        if_req_i = 0; d_req_i = 0;
        gexp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        for (int c = 0; c < 8; c++) check($sformatf("contend_gnt%0d", c), gseq[c], gexp[c]);

        // Reset while a load is waiting for its data.
        @(posedge clk_i); #1;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h810;
        @(negedge clk_i);
        check("mid_gnt", d_gnt_o, 1);
        @(posedge clk_i); #1;
        d_req_i = 0;
        rst_ni = 0;
        #1;
        check("mid_rst_ctrl", 32'({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o,
                                   ram_cs_o, ram_re_o, ram_we_o}), 0);
        @(negedge clk_i);
        #2 rst_ni = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("post_rst_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
        end
        @(posedge clk_i); #1;
        txn(1, 0, 4'h0, 32'h00C, 0);
        check("post_rst_wait", r_waits, 0);

        // Randomized traffic; requesters hold until granted.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_i);
            g_if = if_gnt_o;
            g_d  = d_gnt_o;
            @(posedge clk_i); #1;
            if (!if_req_i || g_if) begin
                if_req_i  = ($urandom_range(0, 2) != 0);
                if_addr_i = pick_addr();
            end
            if (!d_req_i || g_d) begin
                d_req_i = ($urandom_range(0, 2) != 0);
                d_we_i  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       d_be_i = 4'hF;
                    1:       d_be_i = 4'h0;
                    default: d_be_i = 4'($urandom);
                endcase
                rnd_addr  = pick_addr();
                d_addr_i  = rnd_addr;
                d_wdata_i = $urandom;
            end
        end
        if_req_i = 0; d_req_i = 0;
        repeat (4) @(posedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
